arb_mux_reg: RTL and testbench
==============================

// Module: arb_mux_reg
// PURPOSE
//   Parametrised CH-input, n-bit registered multiplexer with round-robin arbitration
//   and valid/ready handshake on every input and on the output. Successor to the
//   2:1 combinational select: it picks among CH requesters itself and holds the
//   result in one output register. Sits between datapath producers, e.g. multiple
//   writeback/forwarding sources, and a single shared consumer.
// PARAMETERS
//   n   32  data width per channel, bits
//   CH  4   number of input channels, >=2
//   CW  derived, localparam: $clog2(CH); channel-index width
// PORTS
//   clk        input   1     clock, rising edge
//   rst        input   1     synchronous reset, active-high
//   in_data    input   CH*n  channel i occupies bits [i*n +: n]
//   in_valid   input   CH    channel i has a beat to offer
//   in_ready   output  CH    channel i beat accepted this cycle (combinational)
//   out_data   output  n     registered selected data
//   out_ch     output  CW    index of channel that produced out_data
//   out_valid  output  1     out_data/out_ch hold a beat
//   out_ready  input   1     consumer takes the beat when out_valid && out_ready
//   in_last    input   CH    only with ARB_MUX_LOCK_EN: final beat of a burst
//   out_last   output  1     only with ARB_MUX_LOCK_EN: registered copy of in_last
// BEHAVIOUR
//   - Reset: out_valid=0, out_data=0, out_ch=0, out_last=0, rr pointer=0, so ch0 has top priority.
//   - load = !out_valid || out_ready. Combinational, same cycle.
//   - grant: one-hot. First valid channel scanning ptr, ptr+1, ... ptr+CH-1, mod CH.
//   - in_ready[i] = grant[i] && load. At most one bit set. Zero when no in_valid.
//   - On a transfer from channel g: out_data<=in_data[g], out_ch<=g, out_valid<=1,
//     and ptr<=(g+1) mod CH. Wrap-around: g=CH-1 gives ptr=0.
//   - Latency 1 cycle, input handshake to out_valid. Full throughput of 1 beat/cycle:
//     a drain and a load in the same cycle are both legal.
//   - out_valid && !out_ready: out_data, out_ch and out_last stay stable. in_ready=0.
//   - Drain with no requester: out_valid<=0. out_data keeps its last value. ptr unchanged.
//   - No in_valid: ptr unchanged. An input may drop in_valid before it is granted.
//   - rst mid-transfer: the beat in the output register is discarded. State returns to reset values on the next edge.
// CONFIGURATION
//   ARB_MUX_LOCK_EN defined: burst lock. After a beat from channel g with in_last[g]=0,
//     grant stays on g, with other channels masked, until a beat with in_last[g]=1 is
//     accepted. Only then does ptr advance to g+1. A locked channel that drops in_valid
//     stalls the mux. out_last registers in_last[g].
//   Not defined: no in_last/out_last ports. Arbitration is redone on every beat.
// STRUCTURE
//   - Shared package mux_pkg: clog2 function; CW calculation, forced to 1 when CH==1.
//   - Sub-module rr_arbiter (#CH): req, ptr, lock -> one-hot grant and binary index.
//     Purely combinational.
//   - Top level holds ptr, the lock flag, the output register, and the one-hot to data select (AND-OR).
// TESTING
//   - Reset, then in_valid=0: out_valid=0, out_data=0, in_ready=0000 for 3 cycles.
//   - Single channel: ch2 drives 0xDEADBEEF with out_ready=1. Next cycle out_valid=1,
//     out_data=0xDEADBEEF, out_ch=2.
//   - All 4 valid, out_ready=1 throughout: grants go 0,1,2,3,0, one per cycle, no bubbles.
//   - Backpressure: hold out_ready=0 for 5 cycles with out_valid=1. out_data is stable
//     and in_ready=0. Release: the next grant is ptr's channel.
//   - rst pulsed while out_valid=1: next cycle out_valid=0, ptr=0, and ch0 wins the next request.
//   - LOCK_EN: ch1 sends a 3-beat burst (last on beat 3) while ch0 and ch2 are valid.
//     out_ch=1,1,1 then 2.

Source files
------------

// File: rtl/arb_mux_reg_pkg.sv
// Shared helpers for the round-robin registered mux: channel-index width calculation.
package mux_pkg;

   function automatic int clog2(input int v);
      for (int r = 0; r < 32; r++)
         if ((1 << r) >= v) return r;
      return 32;
   endfunction

   // A single channel still needs a 1-bit index so out_ch stays a legal port.
   function automatic int ch_width(input int ch);
      return (ch <= 1) ? 1 : clog2(ch);
   endfunction

endpackage

// File: rtl/arb_mux_reg_if.sv
// Handshake bundle between CH producers, the arbitrating mux and one consumer.
// ARB_MUX_LOCK_EN adds the in_last/out_last burst-delimiter signals.
interface arb_mux_reg_if #(parameter int n = 32, parameter int CH = 4);
   import mux_pkg::*;
   localparam int CW = ch_width(CH);

   logic [CH*n-1:0] in_data;
   logic [CH-1:0]   in_valid;
   logic [CH-1:0]   in_ready;
   logic [n-1:0]    out_data;
   logic [CW-1:0]   out_ch;
   logic            out_valid;
   logic            out_ready;
`ifdef ARB_MUX_LOCK_EN
   logic [CH-1:0]   in_last;
   logic            out_last;

   modport master (output in_data, in_valid, in_last, out_ready,
                   input  in_ready, out_data, out_ch, out_valid, out_last);
   modport slave  (input  in_data, in_valid, in_last, out_ready,
                   output in_ready, out_data, out_ch, out_valid, out_last);
`else
   modport master (output in_data, in_valid, out_ready,
                   input  in_ready, out_data, out_ch, out_valid);
   modport slave  (input  in_data, in_valid, out_ready,
                   output in_ready, out_data, out_ch, out_valid);
`endif
endinterface

// File: rtl/arb_mux_reg_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
// With lock set, only the channel at ptr may be granted.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int CH = 4,
   localparam int CW = ch_width(CH)
) (
   input  logic [CH-1:0] req,
   input  logic [CW-1:0] ptr,
   input  logic          lock,
   output logic [CH-1:0] grant,
   output logic [CW-1:0] idx
);

   logic          found;
   int            j;
   logic [CW-1:0] jj;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      jj    = '0;
      for (int k = 0; k < CH; k++) begin
         j = int'(ptr) + k;
         if (j >= CH) j = j - CH;
         jj = CW'(j);
         if (!found && req[jj] && (!lock || k == 0)) begin
            grant[jj] = 1'b1;
            idx       = jj;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arb_mux_reg.sv
// CH-input registered mux with round-robin arbitration and valid/ready on both sides.
// ARB_MUX_LOCK_EN keeps the grant on one channel until its in_last beat is accepted.
module arb_mux_reg
   import mux_pkg::*;
#(
   parameter int n  = 32,
   parameter int CH = 4
) (
   input logic         clk,
   input logic         rst,
   arb_mux_reg_if.slave bus
);

   localparam int CW = ch_width(CH);

   logic [CW-1:0] ptr;
   logic          lock;
   logic [CH-1:0] grant;
   logic [CW-1:0] gidx;
   logic [CW-1:0] ptr_inc;
   logic [n-1:0]  sel_data;
   logic          load;
   logic          xfer;

   rr_arbiter #(.CH(CH)) u_arb (
      .req   (bus.in_valid),
      .ptr   (ptr),
      .lock  (lock),
      .grant (grant),
      .idx   (gidx)
   );

   assign load         = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = grant & {CH{load}};
   assign xfer         = |bus.in_ready;
   assign ptr_inc      = (gidx == CW'(CH - 1)) ? '0 : gidx + 1'b1;

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < CH; i++)
         sel_data = sel_data | (bus.in_data[i*n +: n] & {n{grant[i]}});
   end

`ifdef ARB_MUX_LOCK_EN
   logic out_last_q;
   assign bus.out_last = out_last_q;

   // While locked, ptr parks on the owning channel so the arbiter only looks there.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr        <= '0;
         lock       <= 1'b0;
         out_last_q <= 1'b0;
      end else if (load && xfer) begin
         out_last_q <= bus.in_last[gidx];
         if (bus.in_last[gidx]) begin
            ptr  <= ptr_inc;
            lock <= 1'b0;
         end else begin
            ptr  <= gidx;
            lock <= 1'b1;
         end
      end
   end
`else
   assign lock = 1'b0;

   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (xfer)
         ptr <= ptr_inc;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_ch    <= '0;
      end else if (load) begin
         if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= sel_data;
            bus.out_ch    <= gidx;
         end else begin
            bus.out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arb_mux_reg.sv
// Self-checking bench for arb_mux_reg: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_arb_mux_reg;
   localparam int N  = 32;
   localparam int CH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   arb_mux_reg_if #(.n(N), .CH(CH)) bus ();
   arb_mux_reg #(.n(N), .CH(CH)) dut (.clk(clk), .rst(rst), .bus(bus));

   int vectors = 0;
   int errors  = 0;

   // behavioural model of the arbitration rules
   int          m_ptr   = 0;
   bit          m_lock  = 0;
   bit          m_valid = 0;
   logic [N-1:0] m_data = '0;
   int          m_ch    = 0;
   bit          m_last  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Entered and left at the falling edge; compares DUT against the model, then advances both.
   task automatic step(input logic [CH-1:0] v, input logic [CH*N-1:0] d, input logic r,
                       input logic rs, input logic [CH-1:0] l);
      int g;
      bit ld;
      logic [CH-1:0] exp_rdy;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = r;
      rst           = rs;
`ifdef ARB_MUX_LOCK_EN
      bus.in_last   = l;
`endif
      #1;
      g = -1;
      if (m_lock) begin
         if (v[m_ptr]) g = m_ptr;
      end else begin
         for (int k = 0; k < CH; k++)
            if (g < 0 && v[(m_ptr + k) % CH]) g = (m_ptr + k) % CH;
      end
      ld = !m_valid || r;
      exp_rdy = '0;
      if (ld && g >= 0) exp_rdy[g] = 1'b1;
      chk("in_ready", bus.in_ready, exp_rdy);
      chk("out_valid", bus.out_valid, m_valid);
      chk("out_data", bus.out_data, m_data);
      chk("out_ch", bus.out_ch, m_ch);
`ifdef ARB_MUX_LOCK_EN
      chk("out_last", bus.out_last, m_last);
`endif
      @(posedge clk);
      if (rs) begin
         m_ptr = 0; m_lock = 0; m_valid = 0; m_data = '0; m_ch = 0; m_last = 0;
      end else if (ld) begin
         if (g >= 0) begin
            m_valid = 1;
            m_data  = d[g*N +: N];
            m_ch    = g;
`ifdef ARB_MUX_LOCK_EN
            m_last  = l[g];
            if (l[g]) begin m_ptr = (g + 1) % CH; m_lock = 0; end
            else      begin m_ptr = g;            m_lock = 1; end
`else
            m_ptr   = (g + 1) % CH;
`endif
         end else begin
            m_valid = 0;
         end
      end
      @(negedge clk);
   endtask

   logic [CH*N-1:0] dv;
   logic [CH*N-1:0] rnd;
   logic [N-1:0]    held;
   logic [CH-1:0]   rv;
   logic [CH-1:0]   rl;
   logic [CH-1:0]   all_last;
   int              exp_seq [5] = '{0, 1, 2, 3, 0};

   initial begin
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
`ifdef ARB_MUX_LOCK_EN
      bus.in_last   = '0;
`endif
      all_last = '1;
      for (int i = 0; i < CH; i++) dv[i*N +: N] = N'(32'h1000_0000 * (i + 1) + i);
      @(negedge clk);

      step('0, '0, 1'b0, 1'b1, all_last);
      step('0, '0, 1'b0, 1'b1, all_last);
      for (int c = 0; c < 3; c++) begin
         step('0, '0, 1'b1, 1'b0, all_last);
         chk("rst_out_valid", bus.out_valid, 1'b0);
         chk("rst_out_data", bus.out_data, 32'h0);
         chk("rst_in_ready", bus.in_ready, 4'b0000);
      end

      rnd = '0;
      rnd[2*N +: N] = 32'hDEADBEEF;
      step(4'b0100, rnd, 1'b1, 1'b0, all_last);
      chk("single_valid", bus.out_valid, 1'b1);
      chk("single_data", bus.out_data, 32'hDEADBEEF);
      chk("single_ch", bus.out_ch, 2'd2);

      step('0, '0, 1'b1, 1'b1, all_last);
      for (int c = 0; c < 5; c++) begin
         step(4'b1111, dv, 1'b1, 1'b0, all_last);
         chk("rr_valid", bus.out_valid, 1'b1);
         chk("rr_ch", bus.out_ch, exp_seq[c]);
      end

      held = bus.out_data;
      for (int c = 0; c < 5; c++) begin
         step(4'b1111, dv, 1'b0, 1'b0, all_last);
         chk("bp_data", bus.out_data, held);
         chk("bp_ch", bus.out_ch, 2'd0);
         chk("bp_in_ready", bus.in_ready, 4'b0000);
      end
      step(4'b1111, dv, 1'b1, 1'b0, all_last);
      chk("bp_release_ch", bus.out_ch, 2'd1);

      step(4'b1111, dv, 1'b1, 1'b1, all_last);
      chk("rst_mid_valid", bus.out_valid, 1'b0);
      step(4'b1111, dv, 1'b1, 1'b0, all_last);
      chk("rst_mid_ch0", bus.out_ch, 2'd0);
      chk("rst_mid_data", bus.out_data, dv[0 +: N]);

`ifdef ARB_MUX_LOCK_EN
      step('0, '0, 1'b1, 1'b1, all_last);
      step(4'b0001, dv, 1'b1, 1'b0, all_last);
      step(4'b0111, dv, 1'b1, 1'b0, 4'b1101);
      chk("lock_b1_ch", bus.out_ch, 2'd1);
      chk("lock_b1_last", bus.out_last, 1'b0);
      step(4'b0111, dv, 1'b1, 1'b0, 4'b1101);
      chk("lock_b2_ch", bus.out_ch, 2'd1);
      step(4'b0111, dv, 1'b1, 1'b0, 4'b1111);
      chk("lock_b3_ch", bus.out_ch, 2'd1);
      chk("lock_b3_last", bus.out_last, 1'b1);
      step(4'b0111, dv, 1'b1, 1'b0, 4'b1111);
      chk("lock_after_ch", bus.out_ch, 2'd2);
`endif

      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < CH; i++) rnd[i*N +: N] = $urandom;
         rv = 4'($urandom_range(0, 15));
         rl = 4'($urandom_range(0, 15));
         step(rv, rnd, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0), rl);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
